// File: rtl/jupiter_video_fetch.sv
// Character-mode video fetch and serialiser for the Ace display (32x24 cells of 8x8).
// Owns the pixel H/V counters, reads screen/char RAM on port B, shifts out 1-bit pixels.
module jupiter_video_fetch #(
  parameter int H_TOTAL  = 416,
  parameter int V_TOTAL  = 312,
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 192,
  parameter int HS_START = 320,
  parameter int HS_LEN   = 32,
  parameter int VS_START = 248,
  parameter int VS_LEN   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ce_pix,
  output logic [9:0] scr_addr,
  output logic       scr_oe_n,
  input  logic [7:0] scr_q,
  output logic [9:0] chr_addr,
  output logic       chr_oe_n,
  input  logic [7:0] chr_q,
  output logic       pix,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank
);

  localparam logic [9:0] HT_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] VT_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA      = 10'(H_ACTIVE);
  localparam logic [9:0] VA      = 10'(V_ACTIVE);
  localparam logic [9:0] HW_BEG  = 10'd8;
  localparam logic [9:0] HW_END  = 10'(H_ACTIVE + 8);
  localparam logic [9:0] HS_BEG  = 10'(HS_START);
  localparam logic [9:0] HS_END  = 10'(HS_START + HS_LEN);
  localparam logic [9:0] VS_BEG  = 10'(VS_START);
  localparam logic [9:0] VS_END  = 10'(VS_START + VS_LEN);

  typedef enum logic [2:0] {IDLE, SCR, SCRW, CHR, CHRW} state_t;

  state_t     state;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [2:0] line_q;
  logic       code_inv;
  logic [7:0] pattern;
  logic       inv;
  logic [7:0] shift;

  logic h_act;
  logic v_act;
  logic h_win;
  logic trigger;

  always_comb begin
    h_act   = (hcnt < HA);
    v_act   = (vcnt < VA);
    h_win   = (hcnt >= HW_BEG) && (hcnt < HW_END);
    trigger = ce_pix && (hcnt[2:0] == 3'd0) && h_act && v_act;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce_pix) begin
      if (hcnt == HT_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == VT_LAST) ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // Five-clock fetch: screen code, then pattern row; runs on the fast clock so it
  // always lands before the load point seven pixels after the trigger.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      scr_addr <= '0;
      scr_oe_n <= 1'b1;
      chr_addr <= '0;
      chr_oe_n <= 1'b1;
      line_q   <= '0;
      code_inv <= 1'b0;
      pattern  <= '0;
      inv      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            scr_addr <= {vcnt[7:3], 5'b00000} + {5'b00000, hcnt[7:3]};
            line_q   <= vcnt[2:0];
            scr_oe_n <= 1'b0;
            state    <= SCR;
          end
        end
        SCR: state <= SCRW;
        SCRW: begin
          code_inv <= scr_q[7];
          chr_addr <= {scr_q[6:0], line_q};
          chr_oe_n <= 1'b0;
          scr_oe_n <= 1'b1;
          state    <= CHR;
        end
        CHR: state <= CHRW;
        CHRW: begin
          pattern  <= chr_q;
          inv      <= code_inv;
          chr_oe_n <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The cell fetched at hcnt=8c is loaded at 8c+7, so pixels leave one cell late;
  // the output window is shifted by 8 to match.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift  <= '0;
      pix    <= 1'b0;
      de     <= 1'b0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      hblank <= 1'b1;
      vblank <= 1'b1;
    end else if (ce_pix) begin
      if (hcnt[2:0] == 3'd7)
        shift <= (h_act && v_act) ? (pattern ^ {8{inv}}) : 8'h00;
      else
        shift <= {shift[6:0], 1'b0};
      pix    <= (h_win && v_act) ? shift[7] : 1'b0;
      de     <= h_win && v_act;
      hblank <= !h_win;
      vblank <= !v_act;
      hsync  <= (hcnt >= HS_BEG) && (hcnt < HS_END);
      vsync  <= (vcnt >= VS_BEG) && (vcnt < VS_END);
    end
  end

endmodule

// File: tb/tb_jupiter_video_fetch.sv
// Directed bench for jupiter_video_fetch: full-size instance for fetch/pixel/hsync
// behaviour, plus a shrunken-timing instance to cover vsync and frame wrap quickly.
module tb_jupiter_video_fetch;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       ce_pix;
  logic [9:0] scr_addr, chr_addr;
  logic       scr_oe_n, chr_oe_n;
  logic [7:0] scr_q, chr_q;
  logic       pix, de, hsync, vsync, hblank, vblank;

  logic       reset_s_n;
  logic       ce_s;
  logic [9:0] scr_addr_s, chr_addr_s;
  logic       scr_oe_n_s, chr_oe_n_s;
  logic       pix_s, de_s, hsync_s, vsync_s, hblank_s, vblank_s;
  logic [7:0] zero_q = 8'h00;

  logic [7:0] scr_mem [0:1023];
  logic [7:0] chr_mem [0:1023];

  int tests = 0;
  int fails = 0;
  int hc, vc, ph, pv;
  int hs_c, vs_c, phs, pvs;

  logic [27:0] rst_exp;
  logic [27:0] obs;

  always #5 clock = ~clock;

  jupiter_video_fetch dut (
    .clock(clock), .reset_n(reset_n), .ce_pix(ce_pix),
    .scr_addr(scr_addr), .scr_oe_n(scr_oe_n), .scr_q(scr_q),
    .chr_addr(chr_addr), .chr_oe_n(chr_oe_n), .chr_q(chr_q),
    .pix(pix), .de(de), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank)
  );

  jupiter_video_fetch #(
    .H_TOTAL(64), .V_TOTAL(40), .H_ACTIVE(32), .V_ACTIVE(16),
    .HS_START(40), .HS_LEN(8), .VS_START(24), .VS_LEN(4)
  ) dut_small (
    .clock(clock), .reset_n(reset_s_n), .ce_pix(ce_s),
    .scr_addr(scr_addr_s), .scr_oe_n(scr_oe_n_s), .scr_q(zero_q),
    .chr_addr(chr_addr_s), .chr_oe_n(chr_oe_n_s), .chr_q(zero_q),
    .pix(pix_s), .de(de_s), .hsync(hsync_s), .vsync(vsync_s),
    .hblank(hblank_s), .vblank(vblank_s)
  );

  // Port-B RAM model: registered address, data one clock later.
  always @(posedge clock) begin
    if (!scr_oe_n) scr_q <= scr_mem[scr_addr];
    if (!chr_oe_n) chr_q <= chr_mem[chr_addr];
  end

  task step();
    ce_pix = 1'b1;
    @(posedge clock); #1;
    ce_pix = 1'b0;
    ph = hc;
    pv = vc;
    if (hc == 415) begin
      hc = 0;
      vc = (vc == 311) ? 0 : vc + 1;
    end else begin
      hc = hc + 1;
    end
  endtask

  task step_s();
    ce_s = 1'b1;
    @(posedge clock); #1;
    ce_s = 1'b0;
    phs = hs_c;
    pvs = vs_c;
    if (hs_c == 63) begin
      hs_c = 0;
      vs_c = (vs_c == 39) ? 0 : vs_c + 1;
    end else begin
      hs_c = hs_c + 1;
    end
  endtask

  task run_to(input int h, input int v);
    while (!(hc == h && vc == v)) step();
  endtask

  task test_reset();
    repeat (3) @(posedge clock);
    #1;
    obs = {scr_addr, chr_addr, scr_oe_n, chr_oe_n, pix, de, hsync, vsync, hblank, vblank};
    tests++;
    if (obs !== rst_exp) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %07h expected %07h", obs, rst_exp);
    end
    reset_n = 1'b1;
    hc = 0;
    vc = 0;
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (scr_oe_n !== 1'b1) begin
      fails++;
      $display("[TB] FAIL idle_without_ce: scr_oe_n got %b expected 1", scr_oe_n);
    end
    step();
    tests++;
    if ({scr_oe_n, scr_addr} !== {1'b0, 10'd0}) begin
      fails++;
      $display("[TB] FAIL first_scr_read: got oe_n=%b addr=%0d expected oe_n=0 addr=0", scr_oe_n, scr_addr);
    end
    step();
    step();
    tests++;
    if ({chr_oe_n, chr_addr, scr_oe_n} !== {1'b0, 10'd8, 1'b1}) begin
      fails++;
      $display("[TB] FAIL first_chr_read: got chr_oe_n=%b chr_addr=%0d scr_oe_n=%b expected 0 8 1", chr_oe_n, chr_addr, scr_oe_n);
    end
    step();
    step();
    tests++;
    if (chr_oe_n !== 1'b1) begin
      fails++;
      $display("[TB] FAIL fetch_done: chr_oe_n got %b expected 1", chr_oe_n);
    end
  endtask

  task test_line0();
    logic [7:0] pat;
    logic       exp;
    int         de_cnt;
    pat = 8'hAA;
    de_cnt = 0;
    while (vc == 0) begin
      step();
      if (de) de_cnt++;
      if (ph >= 8 && ph <= 15) begin
        exp = pat[7 - (ph - 8)];
        tests++;
        if (pix !== exp) begin
          fails++;
          $display("[TB] FAIL line0_pix hcnt=%0d: got %b expected %b", ph, pix, exp);
        end
      end
      if (ph == 7 || ph == 8 || ph == 263 || ph == 264) begin
        exp = (ph == 7 || ph == 264);
        tests++;
        if (hblank !== exp) begin
          fails++;
          $display("[TB] FAIL line0_hblank hcnt=%0d: got %b expected %b", ph, hblank, exp);
        end
      end
    end
    tests++;
    if (de_cnt != 256) begin
      fails++;
      $display("[TB] FAIL line0_de_count: got %0d expected 256", de_cnt);
    end
  endtask

  task test_inverse();
    logic [7:0] pat;
    logic       exp;
    logic       seen;
    pat = 8'h0F;
    seen = 1'b0;
    run_to(0, 10);
    while (vc == 10) begin
      step();
      if (!chr_oe_n && chr_addr == 10'h00A) seen = 1'b1;
      if (ph >= 8 && ph <= 23) begin
        exp = (ph >= 16) ? pat[7 - (ph - 16)] : 1'b0;
        tests++;
        if (pix !== exp) begin
          fails++;
          $display("[TB] FAIL inverse_pix hcnt=%0d: got %b expected %b", ph, pix, exp);
        end
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL inverse_chr_addr: got no read of 0x00A expected one");
    end
  endtask

  task test_last_cell();
    logic exp;
    logic seen;
    int   reads;
    seen = 1'b0;
    reads = 0;
    run_to(0, 191);
    while (vc == 191) begin
      step();
      if (!scr_oe_n && scr_addr == 10'd767) seen = 1'b1;
      if (ph >= 256 && ph <= 264) begin
        exp = (ph <= 263);
        tests++;
        if ({pix, de} !== {exp, exp}) begin
          fails++;
          $display("[TB] FAIL last_cell hcnt=%0d: got pix=%b de=%b expected %b %b", ph, pix, de, exp, exp);
        end
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL last_scr_addr: got no read of 767 expected one");
    end
    while (vc == 192) begin
      step();
      if (!scr_oe_n || !chr_oe_n) reads++;
      if (ph == 8) begin
        tests++;
        if ({de, vblank, pix} !== 3'b010) begin
          fails++;
          $display("[TB] FAIL vblank_line192: got de=%b vblank=%b pix=%b expected 0 1 0", de, vblank, pix);
        end
      end
    end
    tests++;
    if (reads != 0) begin
      fails++;
      $display("[TB] FAIL no_read_vblank: got %0d read clocks expected 0", reads);
    end
  endtask

  task test_hsync();
    int   n, first_n, second_n, first_ph, hi_cnt;
    logic prev;
    n = 0;
    first_n = -1;
    second_n = -1;
    first_ph = -1;
    hi_cnt = 0;
    prev = hsync;
    while (vc != 194 || hc <= 330) begin
      step();
      n++;
      if (hsync && !prev) begin
        if (first_n < 0) begin
          first_n = n;
          first_ph = ph;
        end else if (second_n < 0) begin
          second_n = n;
        end
      end
      if (hsync && pv == 193) hi_cnt++;
      prev = hsync;
    end
    tests++;
    if (first_ph != 320) begin
      fails++;
      $display("[TB] FAIL hsync_start: got hcnt %0d expected 320", first_ph);
    end
    tests++;
    if (hi_cnt != 32) begin
      fails++;
      $display("[TB] FAIL hsync_width: got %0d expected 32", hi_cnt);
    end
    tests++;
    if (second_n - first_n != 416) begin
      fails++;
      $display("[TB] FAIL line_period: got %0d clocks expected 416", second_n - first_n);
    end
  endtask

  task test_sparse_ce();
    logic [7:0] pat;
    logic       exp;
    pat = 8'hAA;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    hc = 0;
    vc = 0;
    while (hc <= 96) begin
      repeat (2) begin
        @(posedge clock); #1;
      end
      step();
      if (ph >= 8 && ph <= 15) begin
        exp = pat[7 - (ph - 8)];
        tests++;
        if (pix !== exp) begin
          fails++;
          $display("[TB] FAIL sparse_pix hcnt=%0d: got %b expected %b", ph, pix, exp);
        end
      end
    end
  endtask

  task test_midline_reset();
    int lows;
    lows = 0;
    tests++;
    if ({scr_oe_n, scr_addr, de} !== {1'b0, 10'd12, 1'b1}) begin
      fails++;
      $display("[TB] FAIL pre_reset_state: got oe_n=%b addr=%0d de=%b expected 0 12 1", scr_oe_n, scr_addr, de);
    end
    #2 reset_n = 1'b0;
    #1;
    obs = {scr_addr, chr_addr, scr_oe_n, chr_oe_n, pix, de, hsync, vsync, hblank, vblank};
    tests++;
    if (obs !== rst_exp) begin
      fails++;
      $display("[TB] FAIL midline_reset_outputs: got %07h expected %07h", obs, rst_exp);
    end
    @(negedge clock);
    reset_n = 1'b1;
    hc = 0;
    vc = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (!scr_oe_n || !chr_oe_n) lows++;
    end
    tests++;
    if (lows != 0) begin
      fails++;
      $display("[TB] FAIL no_fetch_residue: got %0d read clocks expected 0", lows);
    end
    step();
    tests++;
    if ({scr_oe_n, scr_addr} !== {1'b0, 10'd0}) begin
      fails++;
      $display("[TB] FAIL restart_scr_read: got oe_n=%b addr=%0d expected 0 0", scr_oe_n, scr_addr);
    end
  endtask

  task test_frame_small();
    logic exp;
    int   vs_lines;
    vs_lines = 0;
    reset_s_n = 1'b1;
    hs_c = 0;
    vs_c = 0;
    for (int i = 0; i < 64 * 42; i++) begin
      step_s();
      if (phs == 0 && i < 64 * 40) begin
        exp = (pvs >= 24 && pvs < 28);
        tests++;
        if (vsync_s !== exp) begin
          fails++;
          $display("[TB] FAIL small_vsync vcnt=%0d: got %b expected %b", pvs, vsync_s, exp);
        end
        if (vsync_s) vs_lines++;
        exp = (pvs >= 16);
        tests++;
        if (vblank_s !== exp) begin
          fails++;
          $display("[TB] FAIL small_vblank vcnt=%0d: got %b expected %b", pvs, vblank_s, exp);
        end
      end
      if (phs == 63 && pvs == 39) begin
        tests++;
        if ({hblank_s, vblank_s} !== 2'b11) begin
          fails++;
          $display("[TB] FAIL small_wrap_last: got hblank=%b vblank=%b expected 1 1", hblank_s, vblank_s);
        end
      end
      if (phs == 0 && pvs == 0 && i > 0) begin
        tests++;
        if ({hblank_s, vblank_s, de_s} !== 3'b100) begin
          fails++;
          $display("[TB] FAIL small_wrap_first: got hblank=%b vblank=%b de=%b expected 1 0 0", hblank_s, vblank_s, de_s);
        end
      end
      if (phs == 8 && pvs == 0 && i > 64) begin
        tests++;
        if ({hblank_s, de_s} !== 2'b01) begin
          fails++;
          $display("[TB] FAIL small_wrap_active: got hblank=%b de=%b expected 0 1", hblank_s, de_s);
        end
      end
    end
    tests++;
    if (vs_lines != 4) begin
      fails++;
      $display("[TB] FAIL small_vsync_lines: got %0d expected 4", vs_lines);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    reset_s_n = 1'b0;
    ce_pix = 1'b0;
    ce_s = 1'b0;
    scr_q = 8'h00;
    chr_q = 8'h00;
    hc = 0;
    vc = 0;
    rst_exp = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 1024; i++) begin
      scr_mem[i] = 8'h00;
      chr_mem[i] = 8'h00;
    end
    scr_mem[0] = 8'h01;
    scr_mem[33] = 8'h81;
    scr_mem[767] = 8'h7F;
    for (int i = 8; i < 16; i++) chr_mem[i] = 8'hAA;
    chr_mem[10] = 8'hF0;
    chr_mem[1023] = 8'hFF;

    test_reset();
    test_line0();
    test_inverse();
    test_last_cell();
    test_hsync();
    test_sparse_ce();
    test_midline_reset();
    test_frame_small();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jupiter_video_fetch.md
Name: jupiter_video_fetch

Overview:
- Character-mode video fetch and serialiser for the Ace display: 32x24 cells of 8x8 pixels.
- Owns the pixel-domain H/V counters.
- Drives the read address of the screen-RAM and char-RAM dual-port blocks (port B, registered address, 1-clock read latency, oe_n gating).
- Turns the returned code/pattern bytes into a 1-bit pixel stream with DE, sync and blank for the scaler/video mixer downstream.

Parameters:
H_TOTAL, 416, pixel clocks per line (multiple of 8)
V_TOTAL, 312, lines per frame
H_ACTIVE, 256, active pixels per line (multiple of 8)
V_ACTIVE, 192, active lines (multiple of 8)
HS_START, 320, hcnt at which hsync asserts
HS_LEN, 32, hsync width in pixels
VS_START, 248, vcnt at which vsync asserts
VS_LEN, 4, vsync width in lines

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce_pix  in  1  pixel clock enable, 1-clock pulse, any spacing >=1 clock
scr_addr  out  10  screen RAM address, row*32+col
scr_oe_n  out  1  screen RAM output enable, active low
scr_q  in  8  screen RAM data (bit7 = inverse, bits6:0 = char code)
chr_addr  out  10  char RAM address {code[6:0], line[2:0]}
chr_oe_n  out  1  char RAM output enable, active low
chr_q  in  8  char pattern row, bit7 = leftmost pixel
pix  out  1  pixel (1 = white), 0 outside active window
de  out  1  display enable
hsync  out  1  active-high horizontal sync
vsync  out  1  active-high vertical sync
hblank  out  1  horizontal blank
vblank  out  1  vertical blank

Behaviour:
- Reset (async, reset_n=0): hcnt=0, vcnt=0, FSM=IDLE, shift=0, code=0, pattern=0. Outputs: scr_addr=0, chr_addr=0, scr_oe_n=1, chr_oe_n=1, pix=0, de=0, hsync=0, vsync=0, hblank=1, vblank=1. Release mid-frame restarts at line 0, pixel 0; no partial-fetch residue.
- Counters advance only on ce_pix. hcnt wraps H_TOTAL-1 -> 0; at that wrap vcnt increments, wrapping V_TOTAL-1 -> 0.
- Fetch trigger: ce_pix && hcnt[2:0]==0 && hcnt<H_ACTIVE && vcnt<V_ACTIVE. Column col=hcnt[7:3], row=vcnt[7:3], line=vcnt[2:0], all latched at trigger.
- FSM, one state per clock, independent of ce_pix after trigger:
  - IDLE -> SCR: drive scr_addr=row*32+col, scr_oe_n=0.
  - SCR -> SCRW: RAM latency cycle.
  - SCRW -> CHR: capture code=scr_q; drive chr_addr={scr_q[6:0],line}, chr_oe_n=0; scr_oe_n=1.
  - CHR -> CHRW: latency cycle.
  - CHRW -> IDLE: capture pattern=chr_q, inv=code[7]; chr_oe_n=1.
  - A fetch completes in 5 clocks, always before the load point, even with ce_pix every clock. A trigger while not IDLE cannot occur; the FSM ignores it.
- Load/shift, on ce_pix:
  - If hcnt[2:0]==7 and the cell just fetched is valid: shift <= pattern ^ {8{inv}}.
  - Otherwise: shift <= shift<<1.
  - pix <= shift[7] while in the active window, else 0.
- Pipeline offset: the pixel for column c, bit b appears on pix when hcnt = 8c+8+b (plus one clock for the output register).
  - Active window: hcnt in [8, H_ACTIVE+8) and vcnt<V_ACTIVE.
  - de = active window.
  - hblank = !(hcnt in window).
  - vblank = (vcnt>=V_ACTIVE).
- Sync: hsync = hcnt in [HS_START, HS_START+HS_LEN). vsync = vcnt in [VS_START, VS_START+VS_LEN).
- All of pix/de/hsync/vsync/hblank/vblank are registered on ce_pix, aligned to the same pixel.
- Outside active lines: no RAM reads (oe_n stay 1), and shift is loaded with 0.
- Arithmetic: scr_addr = {row,5'b0}+col, max 767 in 10 bits. No wrap beyond 767 since row<=23.

Test Plan:
- Reset mid-line (assert at hcnt=100,vcnt=50), release -> all outputs at reset values; first ce_pix gives hcnt=1, vcnt=0; first scr_addr=0 with scr_oe_n=0 on clock 1 after trigger.
- Screen[0]=0x01, char RAM[8..15]=0xAA -> line 0 pixels hcnt 8..15 read 1,0,1,0,1,0,1,0; de=1 over exactly 256 ce_pix per active line.
- Screen[33]=0x81 (inverse, row1 col1), pattern 0xF0 at line 2 -> on vcnt=10, pix at hcnt 16..23 reads 0000_1111; chr_addr=0x00A observed.
- Screen[767]=0x7F, chr[1023]=0xFF -> vcnt=191, hcnt 256..263 all 1; scr_addr=767; no read issued at vcnt=192.
- ce_pix held high continuously -> fetch completes each cell, no dropped or duplicated pattern; 416 clocks/line, hsync high for 32 clocks starting hcnt=320.
- Full frame -> vsync high for vcnt 248..251 only; vblank high for vcnt 192..311; wrap at vcnt 311 -> 0 with hblank/vblank correct at the boundary.
